// File: rtl/bsg_manycore_sdr_reset_pkg.sv
// Shared types for the north-row SDR link reset sequencer: state encoding,
// reset output vector, and the state-to-reset-level lookup.
package bsg_manycore_sdr_reset_pkg;

    typedef enum logic [2:0] {
        ASSERT_ALL  = 3'd0,
        REL_UP      = 3'd1,
        REL_DOWN    = 3'd2,
        REL_TOKEN   = 3'd3,
        REL_DSTREAM = 3'd4,
        REL_CORE    = 3'd5,
        DONE        = 3'd6
    } bsg_sdr_reset_state_e;

    typedef struct packed {
        logic core;
        logic uplink;
        logic downlink;
        logic downstream;
        logic token;
    } bsg_sdr_reset_vec_s;

    // Unknown encodings fall back to everything held in reset.
    function automatic bsg_sdr_reset_vec_s state_to_vec(input bsg_sdr_reset_state_e s);
        bsg_sdr_reset_vec_s v;
        case (s)
            ASSERT_ALL:  v = 5'b11111;
            REL_UP:      v = 5'b10111;
            REL_DOWN:    v = 5'b10011;
            REL_TOKEN:   v = 5'b10010;
            REL_DSTREAM: v = 5'b10000;
            REL_CORE:    v = 5'b00000;
            DONE:        v = 5'b00000;
            default:     v = 5'b11111;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/bsg_sdr_reset_dwell_counter.sv
// Dwell counter for the SDR row reset sequencer: load, decrement, zero flag.
// BSG_SDR_RESET_SEQ_CHAIN_MARGIN_EN adds num_tiles_x_p to every loaded dwell.
module bsg_sdr_reset_dwell_counter #(
    parameter int unsigned step_width_p  = 16,
    parameter int unsigned num_tiles_x_p = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_load,
    input  logic                    i_load_zero,
    input  logic                    i_dec,
    input  logic [step_width_p-1:0] i_dwell,
    output logic                    o_zero_c
);

    // Headroom bits keep D + num_tiles_x_p - 1 representable at max D.
    localparam int unsigned CNT_W = step_width_p + $clog2(num_tiles_x_p + 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_load_val;

    always_comb begin
        w_load_val = CNT_W'(i_dwell) - CNT_W'(1);
`ifdef BSG_SDR_RESET_SEQ_CHAIN_MARGIN_EN
        w_load_val = w_load_val + CNT_W'(num_tiles_x_p);
`endif
        if (i_load_zero) begin
            w_load_val = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= w_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/bsg_manycore_sdr_row_reset_sequencer.sv
// Steps one north-row SDR link chain through its reset release order with a
// latched per-step dwell. Optional: BSG_SDR_RESET_SEQ_CHAIN_MARGIN_EN.
module bsg_manycore_sdr_row_reset_sequencer
    import bsg_manycore_sdr_reset_pkg::*;
#(
    parameter int unsigned num_tiles_x_p = 16,
    parameter int unsigned step_width_p  = 16,
    parameter bit          auto_start_p  = 1'b1
) (
    input  logic                    core_clk_i,
    input  logic                    core_reset_n_i,
    input  logic                    start_i,
    input  logic [step_width_p-1:0] step_cycles_i,
    output logic                    core_reset_o,
    output logic                    async_uplink_reset_o,
    output logic                    async_downlink_reset_o,
    output logic                    async_downstream_reset_o,
    output logic                    async_token_reset_o,
    output logic                    busy_o,
    output logic                    done_o
);

    bsg_sdr_reset_state_e    r_state, w_state_nxt;
    logic                    r_armed, w_armed_nxt;
    logic [step_width_p-1:0] r_dwell, w_dwell_nxt;
    bsg_sdr_reset_vec_s      r_vec;
    logic                    r_busy;
    logic                    r_done;

    logic                    w_load;
    logic                    w_load_zero;
    logic                    w_dec;
    logic                    w_zero;
    logic [step_width_p-1:0] w_dwell_sel;
    logic [step_width_p-1:0] w_dwell_new;

    assign w_dwell_new = (step_cycles_i == '0) ? step_width_p'(1) : step_cycles_i;

    bsg_sdr_reset_dwell_counter #(
        .step_width_p  (step_width_p),
        .num_tiles_x_p (num_tiles_x_p)
    ) u_dwell (
        .clk         (core_clk_i),
        .rst_n       (core_reset_n_i),
        .i_load      (w_load),
        .i_load_zero (w_load_zero),
        .i_dec       (w_dec),
        .i_dwell     (w_dwell_sel),
        .o_zero_c    (w_zero)
    );

    always_ff @(posedge core_clk_i or negedge core_reset_n_i) begin
        if (!core_reset_n_i) begin
            r_state <= ASSERT_ALL;
            r_armed <= 1'b0;
            r_dwell <= step_width_p'(1);
            r_vec   <= 5'b11111;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_armed <= w_armed_nxt;
            r_dwell <= w_dwell_nxt;
            r_vec   <= state_to_vec(w_state_nxt);
            r_busy  <= (w_state_nxt != DONE);
            r_done  <= (w_state_nxt == DONE) && (r_state != DONE);
        end
    end

    // r_armed is clear only while ASSERT_ALL waits for its first start.
    always_comb begin
        w_state_nxt = r_state;
        w_armed_nxt = r_armed;
        w_dwell_nxt = r_dwell;
        w_dwell_sel = r_dwell;
        w_load      = 1'b0;
        w_load_zero = 1'b0;
        w_dec       = 1'b0;
        case (r_state)
            ASSERT_ALL: begin
                if (!r_armed) begin
                    if (auto_start_p || start_i) begin
                        w_armed_nxt = 1'b1;
                        w_dwell_nxt = w_dwell_new;
                        w_dwell_sel = w_dwell_new;
                        w_load      = 1'b1;
                    end
                end else if (w_zero) begin
                    w_state_nxt = REL_UP;
                    w_load      = 1'b1;
                end else begin
                    w_dec = 1'b1;
                end
            end
            REL_UP: begin
                if (w_zero) begin
                    w_state_nxt = REL_DOWN;
                    w_load      = 1'b1;
                end else begin
                    w_dec = 1'b1;
                end
            end
            REL_DOWN: begin
                if (w_zero) begin
                    w_state_nxt = REL_TOKEN;
                    w_load      = 1'b1;
                end else begin
                    w_dec = 1'b1;
                end
            end
            REL_TOKEN: begin
                if (w_zero) begin
                    w_state_nxt = REL_DSTREAM;
                    w_load      = 1'b1;
                end else begin
                    w_dec = 1'b1;
                end
            end
            REL_DSTREAM: begin
                if (w_zero) begin
                    w_state_nxt = REL_CORE;
                    w_load      = 1'b1;
                    w_load_zero = 1'b1;
                end else begin
                    w_dec = 1'b1;
                end
            end
            REL_CORE: begin
                if (w_zero) begin
                    w_state_nxt = DONE;
                end else begin
                    w_dec = 1'b1;
                end
            end
            DONE: begin
                if (start_i) begin
                    w_state_nxt = ASSERT_ALL;
                    w_dwell_nxt = w_dwell_new;
                    w_dwell_sel = w_dwell_new;
                    w_load      = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ASSERT_ALL;
                w_armed_nxt = 1'b0;
            end
        endcase
    end

    assign core_reset_o             = r_vec.core;
    assign async_uplink_reset_o     = r_vec.uplink;
    assign async_downlink_reset_o   = r_vec.downlink;
    assign async_downstream_reset_o = r_vec.downstream;
    assign async_token_reset_o      = r_vec.token;
    assign busy_o                   = r_busy;
    assign done_o                   = r_done;

endmodule

// File: tb/tb_bsg_manycore_sdr_row_reset_sequencer.sv
// Directed bench for the SDR row reset sequencer: per-sequence checkpoint
// table plus hand sequences for ignored starts, dwell relatch and async reset.
module tb_bsg_manycore_sdr_row_reset_sequencer;

`ifdef BSG_SDR_RESET_SEQ_CHAIN_MARGIN_EN
    localparam int M = 16;
`else
    localparam int M = 0;
`endif

    logic        core_clk_i;
    logic        core_reset_n_i;
    logic        start_i;
    logic [15:0] step_cycles_i;
    logic        core_reset_o;
    logic        async_uplink_reset_o;
    logic        async_downlink_reset_o;
    logic        async_downstream_reset_o;
    logic        async_token_reset_o;
    logic        busy_o;
    logic        done_o;

    bsg_manycore_sdr_row_reset_sequencer #(
        .num_tiles_x_p (16),
        .step_width_p  (16),
        .auto_start_p  (1'b1)
    ) dut (
        .core_clk_i               (core_clk_i),
        .core_reset_n_i           (core_reset_n_i),
        .start_i                  (start_i),
        .step_cycles_i            (step_cycles_i),
        .core_reset_o             (core_reset_o),
        .async_uplink_reset_o     (async_uplink_reset_o),
        .async_downlink_reset_o   (async_downlink_reset_o),
        .async_downstream_reset_o (async_downstream_reset_o),
        .async_token_reset_o      (async_token_reset_o),
        .busy_o                   (busy_o),
        .done_o                   (done_o)
    );

    initial core_clk_i = 1'b0;
    always #5 core_clk_i = ~core_clk_i;

    // k counts posedges from the edge that starts the sequence (k = 0).
    typedef struct {
        int         k;
        logic [4:0] vec;
        logic       busy;
        logic       done;
    } chk_t;

    chk_t tbl[13];
    int   total;
    int   bad;

    function automatic logic [4:0] outv();
        return {core_reset_o, async_uplink_reset_o, async_downlink_reset_o,
                async_downstream_reset_o, async_token_reset_o};
    endfunction

    task automatic check(input string nm, input int kk, input logic [4:0] act, input logic [4:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s k=%0d got=%b want=%b", nm, kk, act, exp);
        end
    endtask

    task automatic build_table(input int dw);
        tbl[0]  = '{0,          5'b11111, 1'b1, 1'b0};
        tbl[1]  = '{dw - 1,     5'b11111, 1'b1, 1'b0};
        tbl[2]  = '{dw,         5'b10111, 1'b1, 1'b0};
        tbl[3]  = '{2*dw - 1,   5'b10111, 1'b1, 1'b0};
        tbl[4]  = '{2*dw,       5'b10011, 1'b1, 1'b0};
        tbl[5]  = '{3*dw - 1,   5'b10011, 1'b1, 1'b0};
        tbl[6]  = '{3*dw,       5'b10010, 1'b1, 1'b0};
        tbl[7]  = '{4*dw - 1,   5'b10010, 1'b1, 1'b0};
        tbl[8]  = '{4*dw,       5'b10000, 1'b1, 1'b0};
        tbl[9]  = '{5*dw - 1,   5'b10000, 1'b1, 1'b0};
        tbl[10] = '{5*dw,       5'b00000, 1'b1, 1'b0};
        tbl[11] = '{5*dw + 1,   5'b00000, 1'b0, 1'b1};
        tbl[12] = '{5*dw + 2,   5'b00000, 1'b0, 1'b0};
    endtask

    // Runs one sequence with effective dwell dw; pa/pb/pc are start pulse
    // cycles, chg_k retargets step_cycles_i, stop_k truncates the run.
    task automatic run_seq(input string tag, input int dw, input bit start0,
                           input int pa, input int pb, input int pc,
                           input int chg_k, input logic [15:0] chg_v, input int stop_k);
        int last;
        last = 5*dw + 2;
        if (stop_k >= 0 && stop_k < last) last = stop_k;
        build_table(dw);
        for (int kk = 0; kk <= last; kk++) begin
            start_i = (kk == 0 && start0) || kk == pa || kk == pb || kk == pc;
            if (kk == chg_k) step_cycles_i = chg_v;
            @(posedge core_clk_i);
            #1;
            for (int i = 0; i < 13; i++) begin
                if (tbl[i].k == kk) begin
                    check({tag, "_vec"},  kk, outv(), tbl[i].vec);
                    check({tag, "_busy"}, kk, {4'b0, busy_o}, {4'b0, tbl[i].busy});
                    check({tag, "_done"}, kk, {4'b0, done_o}, {4'b0, tbl[i].done});
                end
            end
        end
        start_i = 1'b0;
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        core_reset_n_i = 1'b0;
        start_i        = 1'b0;
        step_cycles_i  = 16'd4;

        repeat (3) @(posedge core_clk_i);
        #1;
        check("rst_vec",  -1, outv(), 5'b11111);
        check("rst_busy", -1, {4'b0, busy_o}, 5'b00001);
        check("rst_done", -1, {4'b0, done_o}, 5'b00000);

        @(negedge core_clk_i);
        core_reset_n_i = 1'b1;
        run_seq("pwr", 4 + M, 1'b0, -1, -1, -1, -1, 16'd0, -1);

        // Restart from DONE; mid-run and DONE-entry starts are ignored.
        run_seq("ign", 4 + M, 1'b1, 2, 9, 5*(4 + M) + 1, 5, 16'd8, -1);

        run_seq("d8", 8 + M, 1'b1, -1, -1, -1, -1, 16'd0, -1);

        step_cycles_i = 16'd0;
        run_seq("d0", 1 + M, 1'b1, -1, -1, -1, -1, 16'd0, -1);

        // Async reset in the middle of REL_TOKEN.
        step_cycles_i = 16'd4;
        run_seq("arst", 4 + M, 1'b1, -1, -1, -1, -1, 16'd0, 3*(4 + M) + 1);
        check("arst_pre", 3*(4 + M) + 1, outv(), 5'b10010);
        #2;
        core_reset_n_i = 1'b0;
        #1;
        check("arst_vec",  -1, outv(), 5'b11111);
        check("arst_busy", -1, {4'b0, busy_o}, 5'b00001);
        check("arst_done", -1, {4'b0, done_o}, 5'b00000);
        @(negedge core_clk_i);
        core_reset_n_i = 1'b1;
        run_seq("rel", 4 + M, 1'b0, -1, -1, -1, -1, 16'd0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bsg_manycore_sdr_row_reset_sequencer.md
Name: bsg_manycore_sdr_row_reset_sequencer

Overview:
- Controller that drives the reset inputs of one north-row SDR link chain:
  - core reset;
  - async uplink, downlink, downstream and token resets.
- Runs them through a fixed assert/release order, with a programmable dwell between steps.
- Sits beside the row; its outputs drive the row's first-tile reset inputs, and the row propagates them down its daisy chain.
- Re-runs the full sequence on request, for link retraining without a chip reset.

Parameters:
- num_tiles_x_p, 16: tiles in the row; sizes the optional chain-propagation margin.
- step_width_p, 16: width of the dwell counter and of step_cycles_i.
- auto_start_p, 1: when 1, a sequence starts automatically on the first cycle after reset release.

Ports:
- core_clk_i, input, 1: sole clock.
- core_reset_n_i, input, 1: asynchronous, active-low reset.
- start_i, input, 1: request a full sequence; honoured only in DONE.
- step_cycles_i, input, step_width_p: dwell per step, sampled at sequence start.
- core_reset_o, output, 1: to the row's core reset input.
- async_uplink_reset_o, output, 1: async uplink reset.
- async_downlink_reset_o, output, 1: async downlink reset.
- async_downstream_reset_o, output, 1: async downstream reset.
- async_token_reset_o, output, 1: async token reset.
- busy_o, output, 1: sequence in progress.
- done_o, output, 1: one-cycle pulse on entry to DONE.

Behaviour:
- All outputs are registered.
- Reset values while core_reset_n_i=0:
  - all five reset outputs = 1;
  - busy_o = 1;
  - done_o = 0;
  - state = ASSERT_ALL;
  - dwell counter = 0;
  - latched dwell = 1.
- States and output levels (core, up, down, dstream, token):
  - ASSERT_ALL: 1,1,1,1,1
  - REL_UP: 1,0,1,1,1
  - REL_DOWN: 1,0,0,1,1
  - REL_TOKEN: 1,0,0,1,0
  - REL_DSTREAM: 1,0,0,0,0
  - REL_CORE: 0,0,0,0,0
  - DONE: 0,0,0,0,0
- Transitions:
  - The order is ASSERT_ALL -> REL_UP -> REL_DOWN -> REL_TOKEN -> REL_DSTREAM -> REL_CORE -> DONE.
  - Each non-DONE state is held for exactly D cycles, where D is the latched dwell. The counter loads D-1 on state entry, decrements each cycle, and the state advances when it reads 0.
  - REL_CORE has a dwell of 1 cycle and then enters DONE.
- Dwell latching:
  - D is latched from step_cycles_i on the cycle the sequence (re)starts.
  - step_cycles_i = 0 is treated as 1.
  - Width is step_width_p bits unsigned, with no overflow: max D = 2^step_width_p - 1.
- Start after reset:
  - auto_start_p = 1: the first post-reset cycle latches D, and ASSERT_ALL's dwell begins.
  - auto_start_p = 0: the block leaves reset into ASSERT_ALL with busy_o = 1 and waits for start_i, with all resets held asserted.
- In DONE:
  - busy_o = 0.
  - start_i = 1 moves to ASSERT_ALL next cycle: all outputs go to 1, busy_o = 1, D is relatched.
- start_i in any state other than DONE (or the ASSERT_ALL wait when auto_start_p = 0) is ignored, including on the cycle DONE is entered.
- done_o pulses 1 cycle on the DONE entry edge only.
- Mid-sequence core_reset_n_i assertion returns immediately and asynchronously to reset values. No glitch to 0 on any reset output is permitted.
- Monotonicity: within a sequence, every reset output makes at most one 1->0 transition, and makes 0->1 only on restart or reset.
- Total latency, start to done_o = 5·D + 1 cycles.

Optional Feature:
- Macro: BSG_SDR_RESET_SEQ_CHAIN_MARGIN_EN.
- Defined: each dwell becomes D + num_tiles_x_p, covering one register stage per tile in the row's reset daisy chain. Total latency = 5·(D + num_tiles_x_p) + 1.
- Undefined: dwell is exactly D.

Decomposition:
- Shared package bsg_manycore_sdr_reset_pkg holds:
  - the state enum bsg_sdr_reset_state_e (7 states, 3 bits);
  - a packed struct bsg_sdr_reset_vec_s {core, uplink, downlink, downstream, token};
  - a constant lookup function mapping state to reset vector.
- One sub-module: bsg_sdr_reset_dwell_counter (load/decrement/zero flag, step_width_p wide, margin adder under the macro).
- The FSM stays in the top.

Test Plan:
- Power-on with auto_start_p = 1 and step_cycles_i = 4:
  - all outputs 1 during reset;
  - after release, uplink drops at cycle 4, downlink at 8, token at 12, downstream at 16, core at 20;
  - done_o pulses at cycle 21.
- step_cycles_i = 0: sequence behaves as D = 1; done_o at cycle 6.
- start_i pulsed at cycles 2 and 9 mid-sequence (D = 4): both ignored, timing identical to the first test. start_i in DONE: all resets reassert next cycle and the sequence repeats.
- step_cycles_i changed from 4 to 8 mid-sequence: the current sequence keeps D = 4; the next start uses D = 8, giving done_o 41 cycles after start.
- core_reset_n_i asserted during REL_TOKEN: all five outputs go to 1 asynchronously within the same cycle; after release the sequence restarts from ASSERT_ALL.
- With the macro defined, num_tiles_x_p = 16 and D = 4: steps spaced 20 cycles apart; done_o at cycle 101.
